// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI responder (FSM states, CPOL/CPHA
// mode codes, default frame width).
package spi_pkg;

    // Default bits per SPI frame
    localparam int SPI_DATA_W = 8;

    // SPI modes as {cpol, cpha}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchroniser for one asynchronous input, plus a
// rise/fall detector comparing the last two synchronised samples.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], d_i};

    // Move the raw input through the flop chain and remember the previous synchronised sample
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave_rx_tx.sv
// spi_slave_rx_tx: SPI responder running on the system clock. Oversamples
// SCK/SS/MOSI, exchanges one DATA_W-bit frame per select, and offers a
// byte-parallel tx buffer and rx output to local logic.
// Optional build macro SPI_SLAVE_LSB_FIRST_EN adds the lsb_first input.
module spi_slave_rx_tx
    import spi_pkg::*;
#(
    parameter int                DATA_W      = SPI_DATA_W,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX     = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cpol,
    input  logic              cpha,
`ifdef SPI_SLAVE_LSB_FIRST_EN
    input  logic              lsb_first,
`endif
    input  logic              sck,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Bit-order helpers shared by the tx and rx paths
    function automatic logic tx_bit(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] v, input logic b,
                                                    input logic lsb);
        return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    logic lsb_mode;
`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign lsb_mode = lsb_first;
`else
    assign lsb_mode = 1'b0;
`endif

    logic sck_s_unused, sck_rise, sck_fall;
    logic ss_s, ss_rise_unused, ss_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
        .clk_i(clk), .rst_ni(rst), .d_i(sck),
        .sync_o(sck_s_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    // ss resets to the deselected level so miso_oe stays low through reset
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk_i(clk), .rst_ni(rst), .d_i(ss),
        .sync_o(ss_s), .rise_o(ss_rise_unused), .fall_o(ss_fall)
    );

    // mosi shares the synchroniser delay of sck, so it lines up with the detected edge
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk_i(clk), .rst_ni(rst), .d_i(mosi),
        .sync_o(mosi_s), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
    );

    logic [1:0] mode;
    logic       lead_edge, trail_edge, sample_edge, shift_edge, abort;

    assign mode        = {cpol, cpha};
    assign lead_edge   = cpol ? sck_fall : sck_rise;
    assign trail_edge  = cpol ? sck_rise : sck_fall;
    assign sample_edge = ((mode == MODE0) || (mode == MODE2)) ? lead_edge : trail_edge;
    assign shift_edge  = ((mode == MODE1) || (mode == MODE3)) ? lead_edge : trail_edge;
    assign abort       = !en || ss_s;

    spi_state_e        state_q, state_d;
    logic [DATA_W-1:0] tx_buf_q, tx_buf_d;
    logic              tx_ready_q, tx_ready_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              miso_q, miso_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;

    // Next-state and datapath decisions for the frame FSM and tx handshake
    always_comb begin
        state_d    = state_q;
        tx_buf_d   = tx_buf_q;
        tx_ready_d = tx_ready_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        bit_cnt_d  = bit_cnt_q;
        miso_d     = miso_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;

        if (tx_load && tx_ready_q) begin
            tx_buf_d   = tx_data;
            tx_ready_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (en && ss_fall) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                // An empty buffer sends IDLE_TX; a same-cycle load is kept for the next frame
                tx_shift_d = tx_ready_q ? IDLE_TX : tx_buf_q;
                tx_ready_d = 1'b1;
                if (tx_load) begin
                    tx_buf_d   = tx_data;
                    tx_ready_d = 1'b0;
                end
                rx_shift_d = '0;
                bit_cnt_d  = '0;
                if (!cpha) miso_d = tx_bit(tx_shift_d, lsb_mode);
                state_d = abort ? ST_IDLE : ST_SHIFT;
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_insert(rx_shift_q, mosi_s, lsb_mode);
                        if (bit_cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
                        else bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                    // With cpha=0 a shift edge before the first sample is the previous
                    // frame's last trailing edge and must not disturb the fresh MSB.
                    if (shift_edge) begin
                        if (cpha && (bit_cnt_q == '0)) begin
                            miso_d = tx_bit(tx_shift_q, lsb_mode);
                        end else if (bit_cnt_q != '0) begin
                            tx_shift_d = tx_advance(tx_shift_q, lsb_mode);
                            miso_d     = tx_bit(tx_shift_d, lsb_mode);
                        end
                    end
                end
            end
            ST_DONE: begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
                state_d    = (!ss_s && en) ? ST_LOAD : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            tx_buf_q   <= '0;
            tx_ready_q <= 1'b1;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            bit_cnt_q  <= '0;
            miso_q     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_buf_q   <= tx_buf_d;
            tx_ready_q <= tx_ready_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            bit_cnt_q  <= bit_cnt_d;
            miso_q     <= miso_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
        end
    end

    assign miso     = miso_q;
    assign miso_oe  = en & ~ss_s;
    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign busy     = (state_q != ST_IDLE);

endmodule
